// File: rtl/display_pkg.sv
// display_pkg: shared TMDS symbol constants, alignment state type and token test
package display_pkg;

    localparam int TMDS_SYM_W = 10;

    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_SYM_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

    typedef enum logic [1:0] {HUNT, SLIP_WAIT, LOCKED} tmds_align_state_t;

    function automatic logic tmds_is_ctrl(input logic [TMDS_SYM_W-1:0] s);
        return s inside {TMDS_CTRL_00, TMDS_CTRL_01, TMDS_CTRL_10, TMDS_CTRL_11};
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational 10b TMDS symbol to {data, ctrl, is_ctrl}
module tmds_symbol_decode
    import display_pkg::*;
(
    input  logic [TMDS_SYM_W-1:0] sym,
    output logic [7:0]            data,
    output logic [1:0]            ctrl,
    output logic                  is_ctrl
);

    logic [7:0] q;

    // Undo the optional inversion, then the XOR/XNOR chain selected by bit 8
    always_comb begin
        q       = sym[9] ? ~sym[7:0] : sym[7:0];
        data    = {q[7:1] ^ q[6:0] ^ {7{~sym[8]}}, q[0]};
        is_ctrl = tmds_is_ctrl(sym);
        ctrl    = sym == TMDS_CTRL_01 ? 2'b01 :
                  sym == TMDS_CTRL_10 ? 2'b10 :
                  sym == TMDS_CTRL_11 ? 2'b11 : 2'b00;
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: TMDS channel decode with bitslip word alignment; TMDS_ERR_CNT_EN adds a lock-loss counter
module tmds_channel_decoder
    import display_pkg::*;
#(
    parameter int ALIGN_TOKENS = 8,
    parameter int HUNT_CYCLES  = 1024,
    parameter int SLIP_WAIT    = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TMDS_SYM_W-1:0] sym_i,
    output logic [7:0]            data_o,
    output logic [1:0]            ctrl_o,
    output logic                  de_o,
    output logic                  locked_o,
`ifdef TMDS_ERR_CNT_EN
    output logic [15:0]           err_cnt_o,
`endif
    output logic                  bitslip_o
);

    localparam int RW = $clog2(ALIGN_TOKENS) + 1;
    localparam int HW = $clog2(HUNT_CYCLES) + 1;
    localparam int SW = $clog2(SLIP_WAIT) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;

    logic [TMDS_SYM_W-1:0] sym_r;
    logic                  is_ctrl_r;
    logic [7:0]            dec_data;
    logic [1:0]            dec_ctrl;
    logic                  dec_is_ctrl;
    logic                  de_r;
    tmds_align_state_t     state;
    logic [RW-1:0]         run_cnt;
    logic [RW-1:0]         run_nxt;
    logic [HW-1:0]         hunt_cnt;
    logic [SW-1:0]         slip_cnt;
    logic [TW-1:0]         to_cnt;
    logic                  run_full;
    logic                  lock_lost;

    tmds_symbol_decode u_dec (
        .sym     (sym_r),
        .data    (dec_data),
        .ctrl    (dec_ctrl),
        .is_ctrl (dec_is_ctrl)
    );

    assign de_o = de_r & locked_o;

    // Token run length for the aligner; frozen at zero while the deserializer settles
    always_comb begin
        run_nxt   = (!is_ctrl_r || state == display_pkg::SLIP_WAIT) ? '0 :
                    (run_cnt == RW'(ALIGN_TOKENS)) ? run_cnt : run_cnt + 1'b1;
        run_full  = run_nxt == RW'(ALIGN_TOKENS);
        lock_lost = state == LOCKED && !run_full && to_cnt == TW'(LOCK_TIMEOUT - 1);
    end

    // Stage 1 captures the symbol and its token flag, stage 2 the decoded fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_r     <= '0;
            is_ctrl_r <= 1'b0;
            data_o    <= '0;
            ctrl_o    <= '0;
            de_r      <= 1'b0;
        end else begin
            sym_r     <= sym_i;
            is_ctrl_r <= tmds_is_ctrl(sym_i);
            de_r      <= !dec_is_ctrl;
            data_o    <= dec_is_ctrl ? data_o : dec_data;
            ctrl_o    <= dec_is_ctrl ? dec_ctrl : ctrl_o;
        end
    end

    // Alignment FSM: hunt for a token run, slip on timeout, drop lock when runs stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            locked_o  <= 1'b0;
            bitslip_o <= 1'b0;
            run_cnt   <= '0;
            hunt_cnt  <= '0;
            slip_cnt  <= '0;
            to_cnt    <= '0;
        end else begin
            bitslip_o <= 1'b0;
            run_cnt   <= run_nxt;
            case (state)
                HUNT:
                    if (run_full) begin
                        state    <= LOCKED;
                        locked_o <= 1'b1;
                        hunt_cnt <= '0;
                        to_cnt   <= '0;
                    end else if (hunt_cnt == HW'(HUNT_CYCLES - 1)) begin
                        state     <= display_pkg::SLIP_WAIT;
                        bitslip_o <= 1'b1;
                        hunt_cnt  <= '0;
                        slip_cnt  <= '0;
                    end else
                        hunt_cnt <= hunt_cnt + 1'b1;
                display_pkg::SLIP_WAIT:
                    if (slip_cnt == SW'(SLIP_WAIT - 1)) begin
                        state    <= HUNT;
                        hunt_cnt <= '0;
                        slip_cnt <= '0;
                    end else
                        slip_cnt <= slip_cnt + 1'b1;
                LOCKED:
                    if (run_full)
                        to_cnt <= '0;
                    else if (lock_lost) begin
                        state    <= HUNT;
                        locked_o <= 1'b0;
                        run_cnt  <= '0;
                        hunt_cnt <= '0;
                        slip_cnt <= '0;
                        to_cnt   <= '0;
                    end else
                        to_cnt <= to_cnt + 1'b1;
                default:
                    state <= HUNT;
            endcase
        end
    end

`ifdef TMDS_ERR_CNT_EN
    // Saturating count of lock losses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_o <= '0;
        else
            err_cnt_o <= (lock_lost && err_cnt_o != 16'hFFFF) ? err_cnt_o + 1'b1 : err_cnt_o;
    end
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: directed vector table plus alignment corner-case sequences
module tb_tmds_channel_decoder;

    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] DAT00 = 10'b0100000000;

    typedef struct packed {
        logic [9:0] sym;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       de;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sym_i = TOK10;
    logic [7:0] data_o;
    logic [1:0] ctrl_o;
    logic       de_o;
    logic       locked_o;
    logic       bitslip_o;
`ifdef TMDS_ERR_CNT_EN
    logic [15:0] err_cnt_o;
`endif

    int total = 0;
    int passed = 0;
    vec_t vecs[13];

    tmds_channel_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sym_i     (sym_i),
        .data_o    (data_o),
        .ctrl_o    (ctrl_o),
        .de_o      (de_o),
        .locked_o  (locked_o),
`ifdef TMDS_ERR_CNT_EN
        .err_cnt_o (err_cnt_o),
`endif
        .bitslip_o (bitslip_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_lock(input string name);
        int n;
        logic slip;
        n = 0;
        slip = 1'b0;
        sym_i = TOK10;
        while (!locked_o && n < 12) begin
            tick();
            n++;
            slip |= bitslip_o;
        end
        check(name, {30'd0, locked_o, n <= 10}, 32'd3);
        check({name, "_noslip"}, {31'd0, slip}, 32'd0);
    endtask

    initial begin
        int n, pulses, p1, p2;
        logic seen;
        vecs[0]  = '{10'b0100000000, 8'h00, 2'b10, 1'b1};
        vecs[1]  = '{10'b0011111111, 8'hFF, 2'b10, 1'b1};
        vecs[2]  = '{10'b1101010100, 8'hFF, 2'b00, 1'b0};
        vecs[3]  = '{10'b0111111111, 8'h01, 2'b00, 1'b1};
        vecs[4]  = '{10'b1000000000, 8'hFF, 2'b00, 1'b1};
        vecs[5]  = '{10'b0010101011, 8'hFF, 2'b01, 1'b0};
        vecs[6]  = '{10'b1100000000, 8'h01, 2'b01, 1'b1};
        vecs[7]  = '{10'b0101010101, 8'hFF, 2'b01, 1'b1};
        vecs[8]  = '{10'b1010101011, 8'hFF, 2'b11, 1'b0};
        vecs[9]  = '{10'b0001010101, 8'h01, 2'b11, 1'b1};
        vecs[10] = '{10'b0110101010, 8'hFE, 2'b11, 1'b1};
        vecs[11] = '{10'b0100001111, 8'h11, 2'b11, 1'b1};
        vecs[12] = '{10'b0101010100, 8'h11, 2'b10, 1'b0};

        #22;
        check("reset_outputs", {19'd0, data_o, ctrl_o, de_o, locked_o, bitslip_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_lock("initial_lock");
        check("lock_ctrl", {30'd0, ctrl_o}, 32'd2);
        check("lock_de", {31'd0, de_o}, 32'd0);

        sym_i = 10'b0111111111;
        tick();
        sym_i = TOK10;
        check("latency_1cyc_de", {31'd0, de_o}, 32'd0);
        tick();
        check("latency_2cyc", {23'd0, de_o, data_o}, {23'd0, 1'b1, 8'h01});
        tick();
        check("latency_3cyc_de", {31'd0, de_o}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            sym_i = vecs[i].sym;
            tick();
            tick();
            check($sformatf("vec%0d", i), {21'd0, data_o, ctrl_o, de_o},
                  {21'd0, vecs[i].data, vecs[i].ctrl, vecs[i].de});
        end
        repeat (4) tick();

        sym_i = DAT00;
        seen = 1'b0;
        repeat (4000) begin
            tick();
            seen |= bitslip_o;
        end
        check("lock_held", {30'd0, locked_o, de_o}, 32'd3);
        n = 0;
        while (locked_o && n < 300) begin
            tick();
            n++;
            seen |= bitslip_o;
        end
        check("lock_lost", {31'd0, locked_o}, 32'd0);
        check("lost_de", {31'd0, de_o}, 32'd0);
        check("lost_noslip", {31'd0, seen}, 32'd0);
`ifdef TMDS_ERR_CNT_EN
        check("err_cnt", {16'd0, err_cnt_o}, 32'd1);
`endif

        sym_i = DAT00;
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 26; k++) begin
            sym_i = (k == 7 || k >= 15) ? DAT00 : TOK10;
            tick();
            seen |= locked_o;
        end
        check("near_miss_nolock", {31'd0, seen}, 32'd0);
        wait_lock("near_miss_lock");

        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {19'd0, data_o, ctrl_o, de_o, locked_o, bitslip_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_lock("relock");

        sym_i = DAT00;
        do_reset();
        pulses = 0;
        p1 = 0;
        p2 = 0;
        seen = 1'b0;
        for (int k = 1; k <= 2200; k++) begin
            tick();
            seen |= locked_o;
            if (bitslip_o) begin
                pulses++;
                if (pulses == 1) p1 = k;
                if (pulses == 2) p2 = k;
            end
        end
        check("slip_first", p1, 1024);
        check("slip_second", p2, 2064);
        check("slip_count", pulses, 2);
        check("slip_nolock", {31'd0, seen}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
